// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and the fetch-entry type for the instruction-fetch stage.
// Anything that imports this package uses the widths defined here.
package if_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned PC_STEP   = 4;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// The master side issues requests and receives in-order responses.
interface if_fetch_unit_if #(
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32
) ();

    logic               imem_req_valid;
    logic [PC_W-1:0]    imem_req_addr;
    logic               imem_req_ready;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );

endinterface

// File: rtl/if_fetch_unit_sync_fifo.sv
// Single-clock FIFO with a combinational head, synchronous reset and flush.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues imem requests, pairs in-order
// responses with their PCs and presents the head entry to the IF/ID register.
module if_fetch_unit #(
    parameter int unsigned     PC_W     = if_pkg::PC_W,
    parameter int unsigned     INSTR_W  = if_pkg::INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic                clk,
    input  logic                reset,
    if_fetch_unit_if.master     imem,
    input  logic                redirect_valid,
    input  logic [PC_W-1:0]     redirect_pc,
    input  logic                stall,
    output logic [INSTR_W-1:0]  IFinstr,
    output logic [PC_W-1:0]     IFPC,
    output logic                IFvalid
);

    import if_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc_q;
    logic [CW-1:0]   drop_q;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   occ;
    logic [CW:0]     used;
    logic [PC_W-1:0] tag_pc;
    logic            tag_empty;
    logic            tag_full;
    logic            buf_empty;
    logic            buf_full;
    logic            accept;
    logic            rsp;
    logic            dropping;
    logic            buf_push;
    logic            consume;
    fetch_entry_t    buf_in;
    fetch_entry_t    head;
    logic            unused_full;

    // Credit covers both requests still at imem and entries waiting in the buffer,
    // so every accepted request is guaranteed a buffer slot.
    assign used     = {1'b0, inflight} + {1'b0, occ};
    assign imem.imem_req_valid = !reset && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign imem.imem_req_addr  = fetch_pc_q;

    assign accept   = imem.imem_req_valid && imem.imem_req_ready;
    // A response with no outstanding tag is stale (issued before reset) and ignored.
    assign rsp      = imem.imem_rsp_valid && !tag_empty;
    assign dropping = rsp && (drop_q != '0);
    assign buf_push = rsp && !dropping && !redirect_valid;
    assign consume  = !buf_empty && !stall;

    assign buf_in.pc    = tag_pc;
    assign buf_in.instr = imem.imem_rsp_data;

    assign IFvalid = !buf_empty;
    assign IFinstr = IFvalid ? head.instr : INSTR_W'(NOP_INSTR);
    assign IFPC    = IFvalid ? head.pc : '0;

    assign unused_full = tag_full ^ buf_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else if (redirect_valid) begin
            // No accept can happen this cycle, so only the response can retire a tag.
            fetch_pc_q <= redirect_pc;
            drop_q     <= inflight - CW'(rsp);
        end else begin
            if (accept)   fetch_pc_q <= fetch_pc_q + PC_W'(PC_STEP);
            if (dropping) drop_q     <= drop_q - 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .wdata (fetch_pc_q),
        .pop   (rsp),
        .flush (1'b0),
        .rdata (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (inflight)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk   (clk),
        .reset (reset),
        .push  (buf_push),
        .wdata (buf_in),
        .pop   (consume),
        .flush (redirect_valid),
        .rdata (head),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occ)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queue-based in-order imem responder.
module tb_if_fetch_unit;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic [31:0] IFinstr;
    logic [63:0] IFPC;
    logic        IFvalid;

    int checks = 0;
    int errors = 0;

    logic        rsp_hold = 1'b0;
    logic        acc_seen = 1'b0;
    logic [63:0] acc_addr = '0;
    logic [63:0] pend [$];

    if_fetch_unit_if #(.PC_W(64), .INSTR_W(32)) bus ();

    if_fetch_unit #(.PC_W(64), .INSTR_W(32), .RESET_PC(64'h0), .DEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .IFinstr        (IFinstr),
        .IFPC           (IFPC),
        .IFvalid        (IFvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hA500_0000 ^ a[31:0];
    endfunction

    // Imem model: one-cycle latency unless rsp_hold, responses strictly in order.
    always @(negedge clk) begin
        acc_seen = bus.imem_req_valid && bus.imem_req_ready;
        acc_addr = bus.imem_req_addr;
    end

    always @(posedge clk) begin
        #2;
        if (acc_seen) pend.push_back(acc_addr);
        bus.imem_rsp_valid = 1'b0;
        if (!rsp_hold && pend.size() > 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = instr_of(pend.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Holds reset for three edges; returns at the sample point of the first free cycle.
    task automatic do_reset(input logic rdy);
        adv();
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        rsp_hold = 1'b0;
        bus.imem_req_ready = rdy;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        smp();
    endtask

    // Waits (bounded) for the next valid head, checks it and lets it be consumed.
    task automatic expect_next(input string tag, input logic [63:0] pc);
        int n = 0;
        while (!IFvalid && n < 20) begin
            smp();
            n++;
        end
        chk({tag, "_valid"}, 64'(IFvalid), 64'd1);
        chk({tag, "_pc"}, IFPC, pc);
        chk({tag, "_instr"}, 64'(IFinstr), 64'(instr_of(pc)));
        smp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data = '0;
        repeat (2) @(posedge clk);
        smp();
        chk("rst_ifvalid", 64'(IFvalid), 64'd0);
        chk("rst_ifinstr", 64'(IFinstr), 64'h13);
        chk("rst_ifpc", IFPC, 64'h0);
        chk("rst_reqvalid", 64'(bus.imem_req_valid), 64'd0);

        // 1: streaming with a one-cycle imem
        do_reset(1'b1);
        chk("t1_c0_req", 64'(bus.imem_req_valid), 64'd1);
        chk("t1_c0_addr", bus.imem_req_addr, 64'h0);
        chk("t1_c0_ifvalid", 64'(IFvalid), 64'd0);
        adv(); smp();
        chk("t1_c1_ifvalid", 64'(IFvalid), 64'd0);
        chk("t1_c1_addr", bus.imem_req_addr, 64'h4);
        adv(); smp();
        chk("t1_c2_ifvalid", 64'(IFvalid), 64'd1);
        chk("t1_c2_ifpc", IFPC, 64'h0);
        chk("t1_c2_ifinstr", 64'(IFinstr), 64'(instr_of(64'h0)));
        chk("t1_c2_req", 64'(bus.imem_req_valid), 64'd0);
        adv(); smp();
        chk("t1_c3_ifpc", IFPC, 64'h4);
        chk("t1_c3_addr", bus.imem_req_addr, 64'h8);
        adv(); smp();
        expect_next("t1_e8", 64'h8);
        expect_next("t1_e12", 64'hC);

        // 2: stall holds head; credit stops issue; nothing lost or duplicated
        do_reset(1'b1);
        stall = 1'b1;
        repeat (6) begin adv(); smp(); end
        chk("t2_hold_valid", 64'(IFvalid), 64'd1);
        chk("t2_hold_pc", IFPC, 64'h0);
        chk("t2_no_issue", 64'(bus.imem_req_valid), 64'd0);
        adv();
        stall = 1'b0;
        smp();
        expect_next("t2_e0", 64'h0);
        expect_next("t2_e4", 64'h4);
        expect_next("t2_e8", 64'h8);
        expect_next("t2_e12", 64'hC);

        // 3: redirect with two requests outstanding
        do_reset(1'b1);
        rsp_hold = 1'b1;
        adv(); smp();
        chk("t3_c1_addr", bus.imem_req_addr, 64'h4);
        adv();
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        smp();
        chk("t3_redir_noreq", 64'(bus.imem_req_valid), 64'd0);
        adv();
        redirect_valid = 1'b0;
        rsp_hold = 1'b0;
        smp();
        chk("t3_c3_ifvalid", 64'(IFvalid), 64'd0);
        chk("t3_c3_req", 64'(bus.imem_req_valid), 64'd0);
        adv(); smp();
        chk("t3_c4_ifvalid", 64'(IFvalid), 64'd0);
        chk("t3_c4_addr", bus.imem_req_addr, 64'h100);
        adv(); smp();
        chk("t3_c5_ifvalid", 64'(IFvalid), 64'd0);
        expect_next("t3_e100", 64'h100);
        expect_next("t3_e104", 64'h104);

        // 4: back-pressure keeps the request address stable
        do_reset(1'b0);
        chk("t4_c0_addr", bus.imem_req_addr, 64'h0);
        adv(); smp();
        chk("t4_c1_addr", bus.imem_req_addr, 64'h0);
        adv(); smp();
        chk("t4_c2_addr", bus.imem_req_addr, 64'h0);
        chk("t4_c2_req", 64'(bus.imem_req_valid), 64'd1);
        adv();
        bus.imem_req_ready = 1'b1;
        smp();
        chk("t4_c3_addr", bus.imem_req_addr, 64'h0);
        adv(); smp();
        chk("t4_c4_addr", bus.imem_req_addr, 64'h4);
        expect_next("t4_e0", 64'h0);
        expect_next("t4_e4", 64'h4);

        // 5: redirect coincident with a response and a would-be accept
        do_reset(1'b1);
        adv();
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        smp();
        chk("t5_redir_noreq", 64'(bus.imem_req_valid), 64'd0);
        adv();
        redirect_valid = 1'b0;
        smp();
        chk("t5_c2_ifvalid", 64'(IFvalid), 64'd0);
        chk("t5_c2_addr", bus.imem_req_addr, 64'h200);
        adv(); smp();
        chk("t5_c3_ifvalid", 64'(IFvalid), 64'd0);
        expect_next("t5_e200", 64'h200);
        expect_next("t5_e204", 64'h204);

        // 6: PC wrap, then reset in the middle of the stream
        do_reset(1'b1);
        adv();
        redirect_valid = 1'b1;
        redirect_pc = WRAP_PC;
        smp();
        adv();
        redirect_valid = 1'b0;
        smp();
        chk("t6_c2_addr", bus.imem_req_addr, WRAP_PC);
        adv(); smp();
        chk("t6_wrap_addr", bus.imem_req_addr, 64'h0);
        expect_next("t6_efffc", WRAP_PC);
        expect_next("t6_e0", 64'h0);
        adv();
        reset = 1'b1;
        smp();
        chk("t6_rst_req", 64'(bus.imem_req_valid), 64'd0);
        adv(); smp();
        chk("t6_rst_ifvalid", 64'(IFvalid), 64'd0);
        chk("t6_rst_ifpc", IFPC, 64'h0);
        chk("t6_rst_ifinstr", 64'(IFinstr), 64'h13);
        adv();
        reset = 1'b0;
        smp();
        expect_next("t6_post0", 64'h0);
        expect_next("t6_post4", 64'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
